// File: rtl/f1_light_seq.sv
// Start-light sequencer: fills a thermometer lamp bar one lamp per en tick, holds
// for an LFSR-derived number of ticks, then extinguishes and pulses lights_out.
module f1_light_seq #(
    parameter int                N_LIGHTS  = 8,
    parameter int                LFSR_W    = 7,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 7'b1000100,
    parameter int                DELAY_MIN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                trigger,
    input  logic                abort,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                busy,
    output logic                lights_out,
    output logic [LFSR_W:0]     delay_val
);

    localparam int CNT_W = $clog2(N_LIGHTS + 1);
    localparam int DW    = LFSR_W + 1;

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DW-1:0]       hold_q, hold_d;
    logic [DW-1:0]       delay_q, delay_d;
    logic [N_LIGHTS-1:0] data_q, data_d;
    logic                lo_q, lo_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [DW-1:0]       lfsr_delay;

    // Free-running: the hold delay depends on when the fill completes.
    assign lfsr_d     = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    assign lfsr_delay = {1'b0, lfsr_q} + DW'(DELAY_MIN);

    function automatic logic [N_LIGHTS-1:0] therm(input logic [CNT_W-1:0] n);
        logic [N_LIGHTS-1:0] t;
        t = '0;
        for (int i = 0; i < N_LIGHTS; i++) begin
            t[i] = (CNT_W'(i) < n);
        end
        return t;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            hold_q  <= '0;
            delay_q <= '0;
            data_q  <= '0;
            lo_q    <= 1'b0;
            lfsr_q  <= LFSR_W'(1);
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            delay_q <= delay_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
            lfsr_q  <= lfsr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hold_d  = hold_q;
        delay_d = delay_q;
        data_d  = data_q;
        lo_d    = 1'b0;
        if (abort) begin
            state_d = IDLE;
            count_d = '0;
            hold_d  = '0;
            data_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    data_d = '0;
                    if (trigger) begin
                        state_d = FILL;
                        count_d = '0;
                    end
                end
                FILL: begin
                    if (en) begin
                        count_d = count_q + 1'b1;
                        data_d  = therm(count_d);
                        if (count_d == CNT_W'(N_LIGHTS)) begin
                            state_d = HOLD;
                            data_d  = '1;
                            delay_d = lfsr_delay;
                            hold_d  = lfsr_delay;
                        end
                    end
                end
                HOLD: begin
                    data_d = '1;
                    if (en) begin
                        hold_d = hold_q - 1'b1;
                        if (hold_q == DW'(1)) begin
                            state_d = IDLE;
                            count_d = '0;
                            data_d  = '0;
                            lo_d    = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign data_out   = data_q;
    assign busy       = (state_q != IDLE);
    assign lights_out = lo_q;
    assign delay_val  = delay_q;

endmodule

// File: tb/tb_f1_light_seq.sv
// Bench for f1_light_seq: transaction-level model feeds expected lamp changes and
// lights_out pulses into queues; a monitor pops them as the DUT produces them.
module tb_f1_light_seq;

    localparam int N  = 8;
    localparam int P7 = 127;
    localparam int P4 = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0, trigger = 1'b0, abort = 1'b0;
    logic [N-1:0] data_out;
    logic         busy, lights_out;
    logic [7:0]   delay_val;

    logic         s_en = 1'b0, s_trig = 1'b0, s_abort = 1'b0;
    logic [0:0]   n1_data;
    logic         n1_busy, n1_lo;
    logic [4:0]   n1_delay;
    logic [11:0]  n12_data;
    logic         n12_busy, n12_lo;
    logic [4:0]   n12_delay;

    int tests = 0;
    int fails = 0;
    int cyc;
    int tab7[P7];
    int tab4[P4];

    logic [63:0] data_q[$];
    logic [31:0] lo_q[$];

    bit m_busy = 0;
    int m_lit = 0, m_rem = 0, m_delay = 0;
    bit exp_busy = 0;
    int exp_delay = 0;

    f1_light_seq u_dut (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .abort(abort),
        .data_out(data_out), .busy(busy), .lights_out(lights_out), .delay_val(delay_val)
    );

    f1_light_seq #(.N_LIGHTS(1), .LFSR_W(4), .LFSR_TAPS(4'b1001), .DELAY_MIN(1)) u_n1 (
        .clk(clk), .rst(rst), .en(s_en), .trigger(s_trig), .abort(s_abort),
        .data_out(n1_data), .busy(n1_busy), .lights_out(n1_lo), .delay_val(n1_delay)
    );

    f1_light_seq #(.N_LIGHTS(12), .LFSR_W(4), .LFSR_TAPS(4'b1001), .DELAY_MIN(1)) u_n12 (
        .clk(clk), .rst(rst), .en(s_en), .trigger(s_trig), .abort(s_abort),
        .data_out(n12_data), .busy(n12_busy), .lights_out(n12_lo), .delay_val(n12_delay)
    );

    // ---- clock / reset-relative cycle count ----
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

    // ---- helpers ----
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int val);
        tests++;
        fails++;
        $display("FAIL %s: got event at cycle %0d, expected none (tag %0d)", name, cyc, val);
    endtask

    function automatic int lfsr_next(input int x, input int w, input int taps);
        return ((x << 1) & ((1 << w) - 1)) | ($countones(x & taps) & 1);
    endfunction

    function automatic logic [31:0] therm(input int n);
        logic [63:0] t;
        t = (64'd1 << n) - 64'd1;
        return t[31:0];
    endfunction

    // ---- driver with behavioural model: one call per clock cycle ----
    task automatic step(input bit e, input bit t, input bit a);
        int k;
        @(negedge clk);
        en = e; trigger = t; abort = a;
        k = cyc;
        if (a) begin
            if (m_lit != 0) data_q.push_back({32'(k + 1), 32'd0});
            m_busy = 0; m_lit = 0; m_rem = 0;
        end else if (!m_busy) begin
            if (t) begin m_busy = 1; m_lit = 0; end
        end else if (m_lit < N) begin
            if (e) begin
                m_lit++;
                data_q.push_back({32'(k + 1), therm(m_lit)});
                if (m_lit == N) begin
                    m_delay = tab7[k % P7] + 1;
                    m_rem   = m_delay;
                end
            end
        end else if (e) begin
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 0; m_lit = 0;
                data_q.push_back({32'(k + 1), 32'd0});
                lo_q.push_back(32'(k + 1));
            end
        end
        exp_busy  = m_busy;
        exp_delay = m_delay;
    endtask

    task automatic finish_run();
        for (int i = 0; i < 300 && m_busy; i++) step(1, 0, 0);
    endtask

    // ---- monitor / scoreboard ----
    logic [N-1:0] prev_data = '0;
    always @(posedge clk) begin
        logic [63:0] e;
        logic [31:0] t;
        #1;
        if (rst) begin
            prev_data = data_out;
        end else begin
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("delay_val", 64'(delay_val), 64'(exp_delay));
            while (data_q.size() > 0 && int'(data_q[0][63:32]) < cyc) begin
                e = data_q.pop_front();
                flag("data_missing", int'(e[63:32]));
            end
            while (lo_q.size() > 0 && int'(lo_q[0]) < cyc) begin
                t = lo_q.pop_front();
                flag("lights_out_missing", int'(t));
            end
            if (data_out !== prev_data) begin
                if (data_q.size() == 0) begin
                    flag("data_unexpected", int'(data_out));
                end else begin
                    e = data_q.pop_front();
                    chk("data_cycle", 64'(cyc), 64'(e[63:32]));
                    chk("data_out", 64'(data_out), 64'(e[31:0]));
                end
                prev_data = data_out;
            end
            if (lights_out) begin
                if (lo_q.size() == 0) begin
                    flag("lights_out_unexpected", 0);
                end else begin
                    t = lo_q.pop_front();
                    chk("lights_out_cycle", 64'(cyc), 64'(t));
                end
            end
        end
    end

    // ---- stimulus ----
    initial begin
        int n, d1, d12;
        tab7[0] = 1;
        for (int i = 1; i < P7; i++) tab7[i] = lfsr_next(tab7[i-1], 7, 7'h44);
        tab4[0] = 1;
        for (int i = 1; i < P4; i++) tab4[i] = lfsr_next(tab4[i-1], 4, 4'h9);

        repeat (3) @(negedge clk);
        #2;
        chk("rst_data", 64'(data_out), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_lights", 64'(lights_out), 0);
        chk("rst_delay", 64'(delay_val), 0);
        @(negedge clk);
        rst = 1'b0;

        // en in IDLE lights nothing
        repeat (3) begin step(1, 0, 0); step(0, 0, 0); end

        // trigger coincident with en, en every 4th cycle, re-triggers during fill
        step(1, 1, 0);
        for (int i = 0; i < N; i++) begin
            step(0, i == 2, 0); step(0, 0, 0); step(0, i == 5, 0); step(1, 0, 0);
        end
        finish_run();

        // trigger while lights_out is high, then abort after third lamp
        step(0, 1, 0);
        repeat (3) step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        finish_run();

        // randomized traffic
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
        finish_run();
        repeat (3) step(0, 0, 0);

        // asynchronous reset mid-HOLD
        step(0, 1, 0);
        repeat (N) step(1, 0, 0);
        repeat (2) step(0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        data_q.delete(); lo_q.delete();
        m_busy = 0; m_lit = 0; m_rem = 0; m_delay = 0;
        exp_busy = 0; exp_delay = 0;
        #1;
        chk("async_rst_data", 64'(data_out), 0);
        chk("async_rst_busy", 64'(busy), 0);
        chk("async_rst_lights", 64'(lights_out), 0);
        chk("async_rst_delay", 64'(delay_val), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) step(0, 0, 0);

        // N_LIGHTS=1 and N_LIGHTS=12 with a 4-bit LFSR, two runs each
        for (int r = 0; r < 2; r++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            s_trig = 1'b1;
            @(negedge clk);
            s_trig = 1'b0;
            n = 0; d1 = 0; d12 = 0;
            for (int s = 0; s < 80 && (n < 12 || n < 12 + d12 || n < 1 + d1); s++) begin
                @(negedge clk);
                s_en = 1'b1;
                n++;
                if (n == 1)  d1  = tab4[cyc % P4] + 1;
                if (n == 12) d12 = tab4[cyc % P4] + 1;
                @(posedge clk);
                #1;
                chk("n1_data", 64'(n1_data), (n < 1 + d1) ? 64'd1 : 64'd0);
                chk("n1_busy", 64'(n1_busy), 64'(n < 1 + d1));
                chk("n1_lights_out", 64'(n1_lo), 64'(n == 1 + d1));
                chk("n12_data", 64'(n12_data),
                    (n < 12) ? 64'(therm(n)) : ((n < 12 + d12) ? 64'hFFF : 64'd0));
                chk("n12_busy", 64'(n12_busy), 64'(n < 12 || n < 12 + d12));
                chk("n12_lights_out", 64'(n12_lo), 64'(n >= 12 && n == 12 + d12));
                if (n == 1)  chk("n1_delay_val", 64'(n1_delay), 64'(d1));
                if (n == 12) chk("n12_delay_val", 64'(n12_delay), 64'(d12));
            end
            @(negedge clk);
            s_en = 1'b0;
        end

        // main DUT again after reset, LFSR restarted from 1
        step(0, 1, 0);
        finish_run();
        repeat (4) step(0, 0, 0);

        chk("data_queue_drained", 64'(data_q.size()), 0);
        chk("lights_queue_drained", 64'(lo_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
